// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receiver.
//   rx_state_t  - receiver FSM state encoding
//   OVERSAMPLE  - oversample ticks per bit period
//   MID_SAMPLE  - tick count that marks the middle of a bit
//   os_div()    - clocks per oversample tick (integer truncation)
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK_WAIT
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;

    function automatic int os_div(input int clk_freq, input int baud_rate);
        return clk_freq / (baud_rate * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_os_tick_gen.sv
// uart_os_tick_gen: oversample tick generator.
// Pulses tick for one clock every CLK_FREQ/(BAUD_RATE*16) clocks.
//   clk_50mhz - system clock (rising edge)
//   rst_n     - synchronous active-low reset
//   restart   - realign divider: count restarts at 0 on the next edge
//   tick      - one-cycle oversample strobe
module uart_os_tick_gen
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic clk_50mhz,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int OS_DIV = os_div(CLK_FREQ, BAUD_RATE);
    localparam int CW     = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(OS_DIV - 1);

    logic [CW-1:0] div_cnt;

    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (restart || div_cnt == LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == LAST);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, 16x oversampled, LSB first.
//   clk_50mhz    - system clock (rising edge)
//   rst_n        - synchronous active-low reset
//   rx_in        - asynchronous serial line, idle high
//   rx_data      - last correctly received byte
//   rx_valid     - one-cycle pulse, rx_data just updated
//   rx_frame_err - one-cycle pulse, stop bit sampled low
//   rx_busy      - high whenever the FSM is not idle
// Build option: UART_RX_MAJORITY_VOTE_EN - each bit is the 2-of-3 majority
// of the synchronized line at mid-bit -1/0/+1 ticks, decided one tick late.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk_50mhz,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    // ---------------- input synchronizer ----------------
    logic rx_m, rx_s;

    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx_in;
            rx_s <= rx_m;
        end
    end

    // ---------------- oversample tick ----------------
    rx_state_t  state;
    logic       tick;
    logic       restart;

    // Falling line seen in IDLE realigns the divider to the start-bit edge.
    assign restart = (state == ST_IDLE) && !rx_s;

    uart_os_tick_gen #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) u_tick_gen (
        .clk_50mhz (clk_50mhz),
        .rst_n     (rst_n),
        .restart   (restart),
        .tick      (tick)
    );

    // ---------------- sample point ----------------
    // tick_cnt counts ticks mod 16. START decides at count 8 (mid start bit),
    // then the counter is realigned so mid-bit in DATA/STOP lands on the
    // 15->0 wrap. rel is the distance of the incoming tick from mid-bit.
    logic [3:0] tick_cnt;
    logic [3:0] cnt_nxt;
    logic [3:0] mid;
    logic [3:0] rel;
    logic       sample;
    logic       sample_due;

    assign cnt_nxt = tick_cnt + 4'd1;
    assign mid     = (state == ST_START) ? 4'(MID_SAMPLE) : 4'd0;
    assign rel     = cnt_nxt - mid;

`ifdef UART_RX_MAJORITY_VOTE_EN
    // votes[0]: line at mid-1, votes[1]: line at mid; third vote is live rx_s
    logic [1:0] votes;

    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            votes <= 2'b11;
        end else if (tick && rel == 4'd15) begin
            votes[0] <= rx_s;
        end else if (tick && rel == 4'd0) begin
            votes[1] <= rx_s;
        end
    end

    assign sample     = (votes[0] & votes[1]) | (votes[0] & rx_s) | (votes[1] & rx_s);
    assign sample_due = tick && (rel == 4'd1);
`else
    assign sample     = rx_s;
    assign sample_due = tick && (rel == 4'd0);
`endif

    // ---------------- receive FSM ----------------
    logic [2:0] bit_idx;
    logic [7:0] shreg;

    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            tick_cnt     <= 4'd0;
            bit_idx      <= 3'd0;
            shreg        <= 8'h00;
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            if (tick) tick_cnt <= cnt_nxt;

            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        tick_cnt <= 4'd0;
                        state    <= ST_START;
                    end
                end

                ST_START: begin
                    if (sample_due) begin
                        if (!sample) begin
                            // rel is 0 here unless voting delayed the decision
                            // by a tick; carrying it keeps later mid-bits aligned.
                            tick_cnt <= rel;
                            bit_idx  <= 3'd0;
                            state    <= ST_DATA;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end

                ST_DATA: begin
                    if (sample_due) begin
                        shreg   <= {sample, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= ST_STOP;
                    end
                end

                ST_STOP: begin
                    if (sample_due) begin
                        if (sample) begin
                            rx_data  <= shreg;
                            rx_valid <= 1'b1;
                            state    <= ST_IDLE;
                        end else begin
                            rx_frame_err <= 1'b1;
                            state        <= ST_BREAK_WAIT;
                        end
                    end
                end

                ST_BREAK_WAIT: begin
                    if (rx_s) state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign rx_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx.
// Frames are driven at the true line rate (CLK_FREQ/BAUD_RATE clocks per
// bit); expectations come from a frame-level model: good stop bit -> one
// valid pulse carrying the byte, low stop bit -> one frame error and the
// previous byte is kept.
module tb_uart_rx;

    localparam int CLK_FREQ  = 50_000_000;
    localparam int BAUD_RATE = 115200;
    localparam int BIT       = CLK_FREQ / BAUD_RATE;

    logic       clk_50mhz = 1'b0;
    logic       rst_n     = 1'b0;
    logic       rx_in     = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_frame_err;
    logic       rx_busy;

    uart_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk_50mhz    (clk_50mhz),
        .rst_n        (rst_n),
        .rx_in        (rx_in),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_frame_err (rx_frame_err),
        .rx_busy      (rx_busy)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    int checks   = 0;
    int failures = 0;

    // pulse monitor: counts high cycles of each output pulse
    int n_valid = 0;
    int n_ferr  = 0;
    int n_both  = 0;

    always @(negedge clk_50mhz) begin
        if (rst_n) begin
            if (rx_valid) n_valid++;
            if (rx_frame_err) n_ferr++;
            if (rx_valid && rx_frame_err) n_both++;
        end
    end

    initial begin
        repeat (98000) @(posedge clk_50mhz);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx_in = v;
        repeat (n) @(negedge clk_50mhz);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        hold(1'b0, BIT);
        for (int i = 0; i < 8; i++) hold(b[i], BIT);
        hold(stop_ok, BIT);
        rx_in = 1'b1;
    endtask

    task automatic check_frame(input string tag, input int v0, input int f0,
                               input bit ev, input bit ef, input logic [7:0] ed);
        chk({tag, ".valid_pulses"}, n_valid - v0, int'(ev));
        chk({tag, ".ferr_pulses"},  n_ferr - f0,  int'(ef));
        chk({tag, ".rx_data"},      int'(rx_data), int'(ed));
    endtask

    typedef struct {
        logic [7:0] b;
        bit         stop_ok;
        bit         b2b;        // next frame follows with no idle gap
        bit         exp_valid;
        bit         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t       tbl[6];
    logic [7:0] model_data;
    int         v0, f0;

    initial begin
        tbl[0] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5};
        tbl[1] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[2] = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 8'hFF};
        tbl[3] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF};
        tbl[4] = '{8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 8'h80};
        tbl[5] = '{8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 8'h01};

        // ---- reset state ----
        repeat (5) @(negedge clk_50mhz);
        chk("reset.rx_data",      int'(rx_data), 0);
        chk("reset.rx_valid",     int'(rx_valid), 0);
        chk("reset.rx_frame_err", int'(rx_frame_err), 0);
        chk("reset.rx_busy",      int'(rx_busy), 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk_50mhz);

        // ---- table-driven frames ----
        for (int i = 0; i < 6; i++) begin
            v0 = n_valid;
            f0 = n_ferr;
            send_frame(tbl[i].b, tbl[i].stop_ok);
            check_frame($sformatf("tbl%0d", i), v0, f0,
                        tbl[i].exp_valid, tbl[i].exp_ferr, tbl[i].exp_data);
            if (!tbl[i].b2b) begin
                hold(1'b1, BIT);
                chk($sformatf("tbl%0d.idle_busy", i), int'(rx_busy), 0);
            end
        end
        model_data = 8'h01;

        // ---- short low glitch, well under half a bit ----
        v0 = n_valid;
        f0 = n_ferr;
        hold(1'b0, 50);
        chk("glitch.busy_during", int'(rx_busy), 1);
        hold(1'b0, 50);
        hold(1'b1, 2 * BIT);
        chk("glitch.valid_pulses", n_valid - v0, 0);
        chk("glitch.ferr_pulses",  n_ferr - f0, 0);
        chk("glitch.busy_after",   int'(rx_busy), 0);
        chk("glitch.rx_data",      int'(rx_data), int'(model_data));

        // ---- reset in the middle of bit 4 of 8'h55 ----
        begin
            logic [7:0] b55;
            b55 = 8'h55;
            v0 = n_valid;
            f0 = n_ferr;
            hold(1'b0, BIT);
            for (int i = 0; i < 4; i++) hold(b55[i], BIT);
            hold(b55[4], BIT / 2);
            rst_n = 1'b0;
            rx_in = 1'b1;
            repeat (3) @(negedge clk_50mhz);
            chk("midrst.rx_data",      int'(rx_data), 0);
            chk("midrst.rx_valid",     int'(rx_valid), 0);
            chk("midrst.rx_frame_err", int'(rx_frame_err), 0);
            chk("midrst.rx_busy",      int'(rx_busy), 0);
            repeat (5) @(negedge clk_50mhz);
            rst_n = 1'b1;
            hold(1'b1, 2 * BIT);
            chk("midrst.no_valid", n_valid - v0, 0);
            chk("midrst.no_ferr",  n_ferr - f0, 0);
            chk("midrst.idle",     int'(rx_busy), 0);
            v0 = n_valid;
            f0 = n_ferr;
            send_frame(8'h81, 1'b1);
            check_frame("after_rst", v0, f0, 1'b1, 1'b0, 8'h81);
            model_data = 8'h81;
            hold(1'b1, BIT);
        end

        // ---- randomized frames against the frame-level model ----
        for (int i = 0; i < 5; i++) begin
            logic [7:0] b;
            bit         s;
            b = 8'($urandom);
            s = ($urandom_range(0, 3) != 0);
            v0 = n_valid;
            f0 = n_ferr;
            send_frame(b, s);
            if (s) model_data = b;
            check_frame($sformatf("rnd%0d_%02h_%0d", i, b, s), v0, f0, s, !s, model_data);
            // a low stop bit needs the line back high before the next start
            hold(1'b1, s ? $urandom_range(1, BIT) : BIT);
        end

`ifdef UART_RX_MAJORITY_VOTE_EN
        // ---- 1-clock glitch at mid-bit of every data bit of 8'h96 ----
        begin
            logic [7:0] b96;
            b96 = 8'h96;
            v0 = n_valid;
            f0 = n_ferr;
            hold(1'b0, BIT);
            for (int i = 0; i < 8; i++) begin
                hold(b96[i], BIT / 2);
                hold(~b96[i], 1);
                hold(b96[i], BIT - BIT / 2 - 1);
            end
            hold(1'b1, BIT);
            check_frame("vote96", v0, f0, 1'b1, 1'b0, 8'h96);
            hold(1'b1, BIT);
        end
`endif

        chk("never_both", n_both, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
- REQ-001 The block SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
- REQ-002 The block SHALL have parameter BAUD_RATE, default 115200, serial bit rate.
- REQ-003 The block SHALL have port clk_50mhz  input  1  system clock; all logic on its rising edge.
- REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
- REQ-005 The block SHALL have port rx_in  input  1  asynchronous serial line, idle high, 8N1 LSB first.
- REQ-006 The block SHALL have port rx_data  output  8  last correctly received byte.
- REQ-007 The block SHALL have port rx_valid  output  1  one-cycle pulse: rx_data updated.
- REQ-008 The block SHALL have port rx_frame_err  output  1  one-cycle pulse: stop bit sampled low.
- REQ-009 The block SHALL have port rx_busy  output  1  high in any state other than IDLE.

Function
- REQ-010 rx_in SHALL pass through a 2-flop synchronizer (flops reset to 1); all decisions SHALL use the synchronized value rx_s.
- REQ-011 An oversample tick SHALL pulse once every OS_DIV = CLK_FREQ/(BAUD_RATE*16) clocks (27 at defaults, integer truncation); 16 ticks SHALL make one bit period.
- REQ-012 The FSM SHALL have states IDLE, START, DATA, STOP, BREAK_WAIT.
- REQ-013 IDLE: on rx_s==0, the tick divider and the 4-bit tick counter SHALL restart at 0 and the FSM SHALL enter START.
- REQ-014 START: at tick count 8 (mid start bit), if sample==0 the FSM SHALL enter DATA with bit index 0 and tick counter 0, else (glitch) it SHALL return to IDLE with no output pulse.
- REQ-015 DATA: at every tick count 15->0 wrap plus 8 (i.e. mid-bit), the sample SHALL shift into bit 7 of an 8-bit shift register, shifting right; after the 8th bit the FSM SHALL enter STOP.
- REQ-016 STOP: at mid stop bit, sample==1 SHALL load rx_data from the shift register, pulse rx_valid for exactly one cycle, and enter IDLE.
- REQ-017 STOP: sample==0 SHALL pulse rx_frame_err for one cycle, leave rx_data unchanged, and enter BREAK_WAIT.
- REQ-018 BREAK_WAIT SHALL remain until rx_s==1, then enter IDLE; a held-low line (break) SHALL produce exactly one rx_frame_err.
- REQ-019 rx_valid SHALL assert on the clock after the mid stop-bit sample tick; rx_data SHALL hold until the next valid byte.
- REQ-020 rx_valid and rx_frame_err SHALL never assert in the same cycle.
- REQ-021 A new start bit SHALL be accepted in the first cycle IDLE is reached, supporting back-to-back frames with one stop bit.

Reset
- REQ-022 While rst_n==0 at a clock edge: FSM=IDLE, rx_data=8'h00, rx_valid=0, rx_frame_err=0, rx_busy=0, counters=0, synchronizer=1.
- REQ-023 Reset asserted mid-frame SHALL abandon the frame with no pulse; after release, reception SHALL restart only on a fresh falling edge.

Configuration
- REQ-024 With UART_RX_MAJORITY_VOTE_EN defined, each bit sample SHALL be the 2-of-3 majority of rx_s at tick counts 7, 8, 9, decided at tick 9.
- REQ-025 Without UART_RX_MAJORITY_VOTE_EN, each sample SHALL be rx_s at tick count 8 only.

Structure
- REQ-026 Package uart_pkg SHALL hold the rx state enum typedef, OVERSAMPLE=16, and MID_SAMPLE=8; uart_rx SHALL import it.
- REQ-027 Sub-module uart_os_tick_gen (parameters CLK_FREQ, BAUD_RATE; inputs clk_50mhz, rst_n, restart; output tick) SHALL generate the oversample tick.

Verification
- REQ-028 Send 8'hA5 at 115200 -> one rx_valid pulse, rx_data==8'hA5, rx_frame_err never high.
- REQ-029 Send 8'h00 then 8'hFF back-to-back (one stop bit) -> two rx_valid pulses, data 8'h00 then 8'hFF.
- REQ-030 Send 8'h3C with stop bit driven low, then line high -> one rx_frame_err pulse, no rx_valid, rx_data keeps prior value.
- REQ-031 Drive rx_in low for 100 clocks (< half bit) then high -> no pulses, rx_busy returns low, FSM back in IDLE.
- REQ-032 Assert rst_n low during bit 4 of 8'h55 -> outputs at reset values, no pulse; next frame 8'h81 received correctly.
- REQ-033 With UART_RX_MAJORITY_VOTE_EN, inject a 1-clock glitch at tick 8 of each data bit of 8'h96 -> rx_data==8'h96.
